// File: rtl/cordic_rotator.sv
// Rotation-mode CORDIC sequencer producing cos/sin of an FP32 angle by
// time-sharing one external FP32 add/sub unit over x, y and z update cycles.
module cordic_rotator #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] angle,
  output logic        busy,
  output logic        done,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_op,
  input  logic [31:0] fpu_result
);

  typedef enum logic [2:0] {S_IDLE, S_XU, S_YU, S_ZU, S_FIN} state_t;

  localparam logic [31:0] K_INIT = 32'h3F1B74EE;
  localparam logic [4:0]  LAST   = 5'(ITER - 1);

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d, z_q, z_d, xn_q, xn_d;
  logic [31:0] cos_q, cos_d, sin_q, sin_d;
  logic [4:0]  i_q, i_d;
  logic        d_q, d_d, done_q, done_d;
  logic [31:0] op_a, op_b, res;
  logic        op_sub;

  function automatic logic [31:0] atan_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    return 32'h3F490FDB;
      5'd1:    return 32'h3EED6338;
      5'd2:    return 32'h3E7ADBB0;
      5'd3:    return 32'h3DFEADD5;
      5'd4:    return 32'h3D7FAADE;
      5'd5:    return 32'h3CFFEAAE;
      5'd6:    return 32'h3C7FFAAB;
      5'd7:    return 32'h3BFFFEAB;
      5'd8:    return 32'h3B7FFFAB;
      5'd9:    return 32'h3AFFFFEB;
      5'd10:   return 32'h3A7FFFFB;
      5'd11:   return 32'h39FFFFFF;
      5'd12:   return 32'h39800000;
      5'd13:   return 32'h39000000;
      5'd14:   return 32'h38800000;
      5'd15:   return 32'h38000000;
      5'd16:   return 32'h37800000;
      5'd17:   return 32'h37000000;
      5'd18:   return 32'h36800000;
      5'd19:   return 32'h36000000;
      5'd20:   return 32'h35800000;
      5'd21:   return 32'h35000000;
      5'd22:   return 32'h34800000;
      5'd23:   return 32'h34000000;
      default: return 32'h00000000;
    endcase
  endfunction

  // Multiply by 2^-sh through the exponent; anything that would underflow is flushed to +0.
  function automatic logic [31:0] scale(input logic [31:0] v, input logic [4:0] sh);
    logic [7:0] e;
    e = v[30:23];
    if (e <= {3'b000, sh}) return 32'h00000000;
    return {v[31], e - {3'b000, sh}, v[22:0]};
  endfunction

  always_comb begin
    op_a   = 32'h0;
    op_b   = 32'h0;
    op_sub = 1'b0;
    case (state_q)
      S_XU: begin
        op_a   = x_q;
        op_b   = scale(y_q, i_q);
        op_sub = ~z_q[31];
      end
      S_YU: begin
        op_a   = y_q;
        op_b   = scale(x_q, i_q);
        op_sub = ~d_q;
      end
      S_ZU: begin
        op_a   = z_q;
        op_b   = atan_rom(i_q);
        op_sub = d_q;
      end
      default: ;
    endcase
  end

  // The adder always assumes a hidden 1, so zero operands never reach its result.
  always_comb begin
    res = fpu_result;
    if (op_b[30:23] == 8'd0)      res = op_a;
    else if (op_a[30:23] == 8'd0) res = op_sub ? {~op_b[31], op_b[30:0]} : op_b;
    if (res[30:23] == 8'd0)       res = 32'h00000000;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xn_d    = xn_q;
    i_d     = i_q;
    d_d     = d_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        x_d     = K_INIT;
        y_d     = 32'h0;
        z_d     = angle;
        i_d     = 5'd0;
        state_d = S_XU;
      end
      S_XU: begin
        d_d     = ~z_q[31];
        xn_d    = res;
        state_d = S_YU;
      end
      S_YU: begin
        y_d     = res;
        state_d = S_ZU;
      end
      S_ZU: begin
        z_d = res;
        x_d = xn_q;
        if (i_q == LAST) begin
          state_d = S_FIN;
        end else begin
          i_d     = i_q + 5'd1;
          state_d = S_XU;
        end
      end
      S_FIN: begin
        cos_d   = x_q;
        sin_d   = y_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= 32'h0;
      y_q     <= 32'h0;
      z_q     <= 32'h0;
      xn_q    <= 32'h0;
      i_q     <= 5'd0;
      d_q     <= 1'b0;
      cos_q   <= 32'h0;
      sin_q   <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xn_q    <= xn_d;
      i_q     <= i_d;
      d_q     <= d_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign cos_out = cos_q;
  assign sin_out = sin_q;
  assign fpu_a   = op_a;
  assign fpu_b   = op_b;
  assign fpu_op  = op_sub;

endmodule

// File: tb/tb_cordic_rotator.sv
// Bench for cordic_rotator: a real-valued CORDIC/timing model checked every cycle,
// directed angle vectors with literal cos/sin targets, and an ITER=1 instance.
module tb_cordic_rotator;

  localparam int LAT16 = 3 * 16 + 1;
  localparam int LAT1  = 3 * 1 + 1;
  localparam real TOL  = 1.0 / 4096.0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16, start1;
  logic [31:0] angle16, angle1;
  logic        busy16, done16, fpu_op16, busy1, done1, fpu_op1;
  logic [31:0] cos16, sin16, fpu_a16, fpu_b16, fpu_res16;
  logic [31:0] cos1, sin1, fpu_a1, fpu_b1, fpu_res1;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  // FP32 <-> real helpers (exact widening, round-to-nearest-even narrowing)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:23] == 8'd0) return 0.0;
    b = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [24:0] m;
    int          e;
    b = $realtobits(r);
    if (b[62:52] == 11'd0) return 32'h0;
    e = int'({21'd0, b[62:52]}) - 896;
    m = {2'b01, b[51:29]};
    if (b[28] && ((b[27:0] != 28'd0) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e <= 0) return 32'h0;
    if (e >= 255) return {b[63], 8'hFF, 23'd0};
    return {b[63], e[7:0], m[22:0]};
  endfunction

  // Adder stand-in: zero operands give garbage, as the real unit assumes a hidden 1.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'hDEADBEEF;
    return r2f(op ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
  endfunction

  assign fpu_res16 = fpu_model(fpu_a16, fpu_b16, fpu_op16);
  assign fpu_res1  = fpu_model(fpu_a1, fpu_b1, fpu_op1);

  cordic_rotator #(.ITER(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .angle(angle16),
    .busy(busy16), .done(done16), .cos_out(cos16), .sin_out(sin16),
    .fpu_a(fpu_a16), .fpu_b(fpu_b16), .fpu_op(fpu_op16), .fpu_result(fpu_res16)
  );

  cordic_rotator #(.ITER(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .angle(angle1),
    .busy(busy1), .done(done1), .cos_out(cos1), .sin_out(sin1),
    .fpu_a(fpu_a1), .fpu_b(fpu_b1), .fpu_op(fpu_op1), .fpu_result(fpu_res1)
  );

  // Ideal CORDIC in double precision, gain pre-applied through the K start value.
  function automatic void cordic_model(input real ang, input int n, output real c, output real s);
    real x, y, z, xn, p, sg;
    x = f2r(32'h3F1B74EE);
    y = 0.0;
    z = ang;
    p = 1.0;
    for (int k = 0; k < n; k++) begin
      sg = (z >= 0.0) ? 1.0 : -1.0;
      xn = x - sg * y * p;
      y  = y + sg * x * p;
      z  = z - sg * $atan(p);
      x  = xn;
      p  = p / 2.0;
    end
    c = x;
    s = y;
  endfunction

  // Transaction-level model of the ITER=16 instance: acceptance, latency, held results.
  int  m_cnt;
  bit  m_done, m_zero, m_have;
  real m_cos, m_sin, m_cos_p, m_sin_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_zero = 1'b1;
      m_have = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (start16) begin
          m_cnt = 1;
          cordic_model(f2r(angle16), 16, m_cos_p, m_sin_p);
        end
      end else if (m_cnt == LAT16) begin
        m_cnt  = 0;
        m_done = 1'b1;
        m_cos  = m_cos_p;
        m_sin  = m_sin_p;
        m_have = 1'b1;
        m_zero = 1'b0;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic chk_bits(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic chk_near(input string name, input real got, input real exp);
    real diff;
    vec_cnt++;
    diff = got - exp;
    if (diff < 0.0) diff = -diff;
    if (diff > TOL) begin
      err_cnt++;
      $display("FAIL %s got=%f expected=%f (tol 2^-12)", name, got, exp);
    end
  endtask

  task automatic cmp_cycle();
    chk_bits("busy16", {31'd0, busy16}, {31'd0, m_cnt != 0});
    chk_bits("done16", {31'd0, done16}, {31'd0, m_done});
    if (m_cnt == 0) begin
      chk_bits("fpu_idle", {fpu_a16[30:0], fpu_op16} | fpu_b16, 32'h0);
    end
    if (m_zero) begin
      chk_bits("cos16_zero", cos16, 32'h0);
      chk_bits("sin16_zero", sin16, 32'h0);
    end else if (m_have) begin
      chk_near("cos16_model", f2r(cos16), m_cos);
      chk_near("sin16_model", f2r(sin16), m_sin);
    end
  endtask

  // One clock: compare on the falling edge, return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic [31:0] ang, input int pulse_at, input int hold_at);
    bit found;
    found   = 1'b0;
    start16 = 1'b1;
    angle16 = ang;
    tick();
    start16 = 1'b0;
    for (int cyc = 1; cyc <= LAT16 + 20; cyc++) begin
      if (cyc == pulse_at) begin
        start16 = 1'b1;
        angle16 = 32'h3F800000;
      end else if (cyc == pulse_at + 1) begin
        start16 = 1'b0;
      end
      if (cyc == hold_at) start16 = 1'b1;
      tick();
      if (done16) begin
        found = 1'b1;
        chk_bits("lat16", cyc, LAT16);
        break;
      end
    end
    if (!found) chk_bits("done16_timeout", 32'd0, 32'd1);
  endtask

  task automatic run1(input logic [31:0] ang);
    bit found;
    found  = 1'b0;
    start1 = 1'b1;
    angle1 = ang;
    tick();
    start1 = 1'b0;
    for (int cyc = 1; cyc <= LAT1 + 20; cyc++) begin
      tick();
      if (done1) begin
        found = 1'b1;
        chk_bits("lat1", cyc, LAT1);
        break;
      end
    end
    if (!found) chk_bits("done1_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    real c, s;
    rst_n   = 1'b0;
    start16 = 1'b0;
    start1  = 1'b0;
    angle16 = 32'h0;
    angle1  = 32'h0;
    repeat (3) tick();
    chk_bits("rst_busy16", {31'd0, busy16}, 32'd0);
    chk_bits("rst_done16", {31'd0, done16}, 32'd0);
    chk_bits("rst_fpu_a16", fpu_a16, 32'h0);
    chk_bits("rst_cos1", cos1, 32'h0);
    chk_bits("rst_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;
    tick();

    cordic_model(0.0, 16, c, s);
    chk_near("model_cos_0", c, 1.0);
    chk_near("model_sin_0", s, 0.0);
    cordic_model(0.5235987756, 16, c, s);
    chk_near("model_cos_pi6", c, 0.8660254);
    chk_near("model_sin_pi6", s, 0.5);
    cordic_model(-0.7853981634, 16, c, s);
    chk_near("model_sin_mpi4", s, -0.70710678);

    run16(32'h00000000, -1, -1);
    chk_near("cos_a0", f2r(cos16), 1.0);
    chk_near("sin_a0", f2r(sin16), 0.0);

    // A re-pulse mid-run is ignored; start held through FIN is taken only in IDLE.
    run16(32'h3F060A92, 10, LAT16);
    chk_near("cos_pi6", f2r(cos16), f2r(32'h3F5DB3D7));
    chk_near("sin_pi6", f2r(sin16), f2r(32'h3F000000));

    run16(32'hBF490FDB, -1, -1);
    chk_near("cos_mpi4", f2r(cos16), f2r(32'h3F3504F3));
    chk_near("sin_mpi4", f2r(sin16), f2r(32'hBF3504F3));
    chk_bits("sin_mpi4_sign", {31'd0, sin16[31]}, 32'd1);

    start16 = 1'b1;
    angle16 = 32'h3F060A92;
    tick();
    start16 = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk_bits("midrst_busy", {31'd0, busy16}, 32'd0);
    chk_bits("midrst_done", {31'd0, done16}, 32'd0);
    chk_bits("midrst_cos", cos16, 32'h0);
    chk_bits("midrst_sin", sin16, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run16(32'h00000000, -1, -1);
    chk_near("cos_after_rst", f2r(cos16), 1.0);

    run1(32'h3F490FDB);
    chk_bits("cos1_pi4", cos1, 32'h3F1B74EE);
    chk_bits("sin1_pi4", sin1, 32'h3F1B74EE);
    run1(32'hBF000000);
    chk_bits("cos1_neg", cos1, 32'h3F1B74EE);
    chk_bits("sin1_neg", sin1, 32'hBF1B74EE);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
